// File: rtl/led_blink_scheduler.sv
// led_blink_scheduler
// Arbitrates the four board LEDs (LED12..LED15) between up to four requesters.
// The lowest-index requester wins and plays a latched pattern for a number of
// TICK_DIV-cycle phases, alternating pattern / dark. With no owner, the LEDs
// show a slow all-on / all-off heartbeat. Every output is a flop output.
module led_blink_scheduler #(
  parameter int unsigned           TICK_W   = 28,
  parameter logic [TICK_W-1:0]     TICK_DIV = 28'h4000000
) (
  input  logic        osc_clk,
  input  logic        RST_N,
  input  logic [3:0]  req,
  input  logic [15:0] pat,
  input  logic [15:0] cnt,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic        busy,
  output logic        LED12,
  output logic        LED13,
  output logic        LED14,
  output logic        LED15
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_DIV - 1'b1;

  // Fixed priority: bit 0 is the most important requester.
  function automatic logic [1:0] pick_lowest(input logic [3:0] r);
    if (r[0])      return 2'd0;
    else if (r[1]) return 2'd1;
    else if (r[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // A phase count of zero still plays one phase.
  function automatic logic [3:0] clamp_min1(input logic [3:0] c);
    return (c == 4'd0) ? 4'd1 : c;
  endfunction

  // LED image for a given controller state.
  function automatic logic [3:0] led_image(input logic [1:0] st,
                                           input logic       hb,
                                           input logic       ph,
                                           input logic [3:0] sp);
    logic [3:0] img;
    img = 4'b0000;
    if (st == ST_IDLE)
      img = {4{hb}};
    else if (st == ST_PLAY)
      img = ph ? 4'b0000 : sp;
    return img;
  endfunction

  // Registered state (stage 1)
  logic [1:0]        state_p1;
  logic [TICK_W-1:0] tcnt_p1;
  logic              hb_p1;
  logic [3:0]        rem_p1;
  logic              phase_p1;
  logic [3:0]        spat_p1;
  logic [3:0]        own_p1;
  logic [3:0]        grant_p1;
  logic [3:0]        done_p1;
  logic              busy_p1;
  logic [3:0]        led_p1;

  // Next-state decision (stage 0)
  logic [1:0]        state_p0;
  logic [TICK_W-1:0] tcnt_p0;
  logic              hb_p0;
  logic [3:0]        rem_p0;
  logic              phase_p0;
  logic [3:0]        spat_p0;
  logic [3:0]        own_p0;
  logic              tick_p0;
  logic [1:0]        win_p0;
  logic              owner_held_p0;

  assign tick_p0       = (tcnt_p1 == TICK_LAST);
  assign win_p0        = pick_lowest(req);
  assign owner_held_p0 = |(req & own_p1);

  // Next-state logic: tick counter, heartbeat, arbitration and play sequencing.
  always_comb begin
    state_p0 = state_p1;
    tcnt_p0  = tick_p0 ? '0 : tcnt_p1 + 1'b1;
    hb_p0    = hb_p1;
    rem_p0   = rem_p1;
    phase_p0 = phase_p1;
    spat_p0  = spat_p1;
    own_p0   = own_p1;

    case (state_p1)
      ST_IDLE: begin
        if (tick_p0)
          hb_p0 = ~hb_p1;
        if (req != 4'b0000) begin
          // Latch the winner's pattern and count so later input changes
          // cannot disturb the play; restart the phase timer.
          own_p0   = 4'b0001 << win_p0;
          spat_p0  = pat[{win_p0, 2'b00} +: 4];
          rem_p0   = clamp_min1(cnt[{win_p0, 2'b00} +: 4]);
          phase_p0 = 1'b0;
          tcnt_p0  = '0;
          state_p0 = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (!owner_held_p0) begin
          // Owner withdrew: abort immediately, independent of the tick.
          state_p0 = ST_DONE;
        end else if (tick_p0) begin
          if (rem_p1 == 4'd1) begin
            state_p0 = ST_DONE;
          end else begin
            rem_p0   = rem_p1 - 4'd1;
            phase_p0 = ~phase_p1;
          end
        end
      end

      ST_DONE: begin
        // Heartbeat restarts cleanly from dark with a full first period.
        hb_p0    = 1'b0;
        tcnt_p0  = '0;
        own_p0   = 4'b0000;
        state_p0 = ST_IDLE;
      end

      default: begin
        state_p0 = ST_IDLE;
        own_p0   = 4'b0000;
      end
    endcase
  end

  // Controller state registers; reset returns to a dark, idle scheduler.
  always_ff @(posedge osc_clk or negedge RST_N) begin
    if (!RST_N) begin
      state_p1 <= ST_IDLE;
      tcnt_p1  <= '0;
      hb_p1    <= 1'b0;
      rem_p1   <= 4'd0;
      phase_p1 <= 1'b0;
      spat_p1  <= 4'b0000;
      own_p1   <= 4'b0000;
    end else begin
      state_p1 <= state_p0;
      tcnt_p1  <= tcnt_p0;
      hb_p1    <= hb_p0;
      rem_p1   <= rem_p0;
      phase_p1 <= phase_p0;
      spat_p1  <= spat_p0;
      own_p1   <= own_p0;
    end
  end

  // Output registers are loaded from the next state so they change in the
  // same cycle as the state they describe, with no combinational outputs.
  always_ff @(posedge osc_clk or negedge RST_N) begin
    if (!RST_N) begin
      grant_p1 <= 4'b0000;
      done_p1  <= 4'b0000;
      busy_p1  <= 1'b0;
      led_p1   <= 4'b0000;
    end else begin
      grant_p1 <= (state_p0 == ST_PLAY) ? own_p0 : 4'b0000;
      done_p1  <= (state_p0 == ST_DONE) ? own_p0 : 4'b0000;
      busy_p1  <= (state_p0 != ST_IDLE);
      led_p1   <= led_image(state_p0, hb_p0, phase_p0, spat_p0);
    end
  end

  assign grant = grant_p1;
  assign done  = done_p1;
  assign busy  = busy_p1;
  assign LED12 = led_p1[0];
  assign LED13 = led_p1[1];
  assign LED14 = led_p1[2];
  assign LED15 = led_p1[3];

endmodule

// File: doc/led_blink_scheduler.md
# led_blink_scheduler

Shares the board's four LEDs (LED12–LED15) between up to four requesters, each of which plays a short blink pattern. Sits between the internal oscillator clock (OSCA HFCLKOUT) and the LED pins, replacing the free-running toggle with a timed, arbitrated scheduler. When no requester holds the LEDs, it falls back to an all-LED heartbeat.

## Interface
- TICK_W, 28: width of the phase-tick counter.
- TICK_DIV, 28'h4000000: clock cycles per blink phase. Legal range is 2 to 2^TICK_W−1. About 0.15 s at 450 MHz.

- osc_clk  in  1  sole clock (internal oscillator HFCLKOUT).
- RST_N  in  1  asynchronous, active-low reset.
- req  in  4  level request per requester; bit 0 has highest priority.
- pat  in  16  LED pattern per requester; requester i uses pat[4i+3:4i].
- cnt  in  16  phase count per requester; requester i uses cnt[4i+3:4i]. A value of 0 is treated as 1.
- grant  out  4  one-hot; marks the current LED owner.
- done  out  4  one-cycle pulse to the owner when its play ends.
- busy  out  1  high whenever state ≠ IDLE.
- LED12, LED13, LED14, LED15  out  1 each  LED drive; LED12 = bit 0 through LED15 = bit 3.

## Operation
- **Tick generator**
  - tcnt counts 0..TICK_DIV−1 and wraps to 0.
  - tick is high for the one cycle where tcnt == TICK_DIV−1.
  - tcnt is forced to 0 on the IDLE→PLAY transition, so the first phase is full length.
- **FSM states:** IDLE, PLAY, DONE. Reset state is IDLE.
- **IDLE**
  - LEDs = {4{hb}}; hb toggles on every tick.
  - If req ≠ 0 at a clock edge, the lowest set index w wins:
    - pat_w and max(cnt_w, 1) are latched into shadow registers (spat, rem).
    - phase bit is cleared to 0.
    - grant becomes onehot(w) and the FSM goes to PLAY.
  - If req == 0, the FSM stays in IDLE.
- **PLAY**
  - LEDs = spat when phase = 0, and 4'b0000 when phase = 1.
  - Later changes on pat or cnt are ignored.
  - On tick with rem == 1, go to DONE.
  - On tick with rem > 1, decrement rem and toggle phase.
  - Abort: if req[w] is sampled low, go to DONE at that edge, regardless of tick.
  - There is no preemption; higher-priority requests wait.
- **DONE** (exactly one cycle)
  - done[w] = 1, grant = 0, LEDs = 0000.
  - hb and tcnt are cleared; req is not sampled.
  - Next state is IDLE.
- **Requester contract:** deassert req by the edge ending the cycle after done. A still-high req is re-granted.
- **Arbitration:** fixed priority. Requesters are not protected from starvation.
- **Reset:** RST_N low at any time, including mid-PLAY, immediately forces the FSM to IDLE and clears tcnt, hb, rem, phase and spat.
  - Reset outputs: grant = 0, done = 0, busy = 0, all LEDs = 0.

## Timing
- **Grant latency:** req sampled in IDLE at edge E gives grant and busy high from E onward (registered; 1 cycle).
- **LED outputs:** registered; they show the PLAY pattern in the same cycle grant rises.
- **Phase length:** exactly TICK_DIV cycles.
- **PLAY duration:** max(cnt, 1)·TICK_DIV cycles.
- **done pulse:** occupies the cycle immediately after the final PLAY cycle. busy falls one cycle after that.
- **Abort:** req[w] sampled low at edge E makes DONE the cycle starting at E.
- **Idle heartbeat:** restarts from hb = 0; the first toggle comes TICK_DIV cycles after entry to IDLE.
- **Outputs:** all are glitch-free register outputs; there are no combinational input-to-output paths.

## Test plan
- **Reset and heartbeat** (TICK_DIV = 4): assert RST_N low mid-cycle → all outputs 0 with no clock edge. After release → LED12–15 toggle together every 4 cycles.
- **Single request:** req = 0100, pat[11:8] = 1010, cnt[11:8] = 3 → grant = 0100 one cycle later. LEDs are 1010 for 4 cycles, 0000 for 4, then 1010 for 4. done = 0100 for one cycle 12 cycles after grant, then busy low.
- **Contention:** req[1] and req[3] raised in the same cycle, both held → grant 0010 first. req[3] stays pending; after done[1] and req[1] drops → grant 1000.
- **cnt = 0:** → exactly one 4-cycle phase showing pat, then done.
- **Abort:** drop req[w] in the 2nd cycle of PLAY → DONE the next cycle, done[w] pulse, LEDs 0000, back to IDLE.
- **Reset during PLAY:** assert RST_N low → outputs 0 immediately. After release with req still high → fresh grant one cycle later, with the full cnt replayed.
